// File: rtl/led_pkg.sv
// Shared types and defaults for the LED matrix row scanner.
package led_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam int DEF_ROWS         = 8;
    localparam int DEF_COLS         = 8;
    localparam int DEF_PWM_BITS     = 4;
    localparam int DEF_BLANK_CYCLES = 2;

    // Cycles spent on one row: the all-off guard plus the full PWM window.
    function automatic int row_period(input int blank_cycles, input int pwm_bits);
        return blank_cycles + (1 << pwm_bits);
    endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Pending/active double buffer. The producer fills the pending half through a
// valid/ready handshake; the scanner copies it to the active half on swap.
module led_frame_buffer
    import led_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [ROWS*COLS-1:0]           red_in,
    input  logic [ROWS*COLS-1:0]           green_in,
    input  logic                           frame_valid,
    output logic                           frame_ready,
    input  logic                           swap,
    output logic [ROWS-1:0][COLS-1:0]      active_red,
    output logic [ROWS-1:0][COLS-1:0]      active_green
);

    logic [ROWS-1:0][COLS-1:0] pend_red;
    logic [ROWS-1:0][COLS-1:0] pend_green;
    logic                      pending_full;

    // Ready purely reflects the flag so the producer sees it without a bubble.
    assign frame_ready = !pending_full;

    // Accept and swap are mutually exclusive: accept needs the pending half
    // empty, swap only acts when it is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_red     <= '0;
            pend_green   <= '0;
            active_red   <= '0;
            active_green <= '0;
            pending_full <= 1'b0;
        end else if (frame_valid && frame_ready) begin
            pend_red     <= red_in;
            pend_green   <= green_in;
            pending_full <= 1'b1;
        end else if (swap && pending_full) begin
            active_red   <= pend_red;
            active_green <= pend_green;
            pending_full <= 1'b0;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-scanning bi-colour LED matrix driver with per-row blanking, PWM
// brightness, scan enable and a double-buffered frame load.
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int PWM_BITS     = DEF_PWM_BITS,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [PWM_BITS-1:0]    brightness,
    input  logic [ROWS*COLS-1:0]   red_in,
    input  logic [ROWS*COLS-1:0]   green_in,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic [COLS-1:0]        red_drv,
    output logic [COLS-1:0]        green_drv,
    output logic [ROWS-1:0]        row_sink,
    output logic                   frame_start
);

    localparam int RW   = $clog2(ROWS);
    localparam int PH_W = ($clog2(BLANK_CYCLES) > PWM_BITS) ? $clog2(BLANK_CYCLES) : PWM_BITS;

    localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_CYCLES - 1);
    localparam logic [PH_W-1:0] DRIVE_LAST = PH_W'((1 << PWM_BITS) - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);

    scan_state_t          state, state_nx;
    logic [RW-1:0]        row, row_nx;
    logic [PH_W-1:0]      phase, phase_nx;
    logic [PWM_BITS-1:0]  bright_q;
    logic                 frame_edge;
    logic                 swap;

    logic [ROWS-1:0][COLS-1:0] active_red;
    logic [ROWS-1:0][COLS-1:0] active_green;

    // First cycle of row 0 blanking: frame boundary for swap and frame_start.
    assign frame_edge = enable && (state == BLANK) && (row == '0) && (phase == '0);
    // While disabled nothing is displayed, so a pending frame may go live at once.
    assign swap       = !enable || frame_edge;

    led_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .red_in       (red_in),
        .green_in     (green_in),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .swap         (swap),
        .active_red   (active_red),
        .active_green (active_green)
    );

    // Scan position register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BLANK;
            row   <= '0;
            phase <= '0;
        end else begin
            state <= state_nx;
            row   <= row_nx;
            phase <= phase_nx;
        end
    end

    // Next scan position; disable parks the scanner at the start of a frame.
    always_comb begin
        state_nx = state;
        row_nx   = row;
        phase_nx = phase;
        if (!enable) begin
            state_nx = BLANK;
            row_nx   = '0;
            phase_nx = '0;
        end else begin
            case (state)
                BLANK: begin
                    if (phase == BLANK_LAST) begin
                        state_nx = DRIVE;
                        phase_nx = '0;
                    end else begin
                        phase_nx = phase + 1'b1;
                    end
                end
                DRIVE: begin
                    if (phase == DRIVE_LAST) begin
                        state_nx = BLANK;
                        phase_nx = '0;
                        row_nx   = (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        phase_nx = phase + 1'b1;
                    end
                end
                default: begin
                    state_nx = BLANK;
                    row_nx   = '0;
                    phase_nx = '0;
                end
            endcase
        end
    end

    // Latch brightness as the row enters DRIVE so a mid-row change cannot glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= '0;
        end else if (enable && (state == BLANK) && (phase == BLANK_LAST)) begin
            bright_q <= brightness;
        end
    end

    // Registered pin drive, one cycle behind the scan position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_sink    <= '1;
            red_drv     <= '0;
            green_drv   <= '0;
            frame_start <= 1'b0;
        end else begin
            row_sink    <= '1;
            red_drv     <= '0;
            green_drv   <= '0;
            frame_start <= frame_edge;
            if (enable && (state == DRIVE)) begin
                row_sink <= ~(ROWS'(1) << row);
                if (phase < PH_W'(bright_q)) begin
                    red_drv   <= active_red[row];
                    green_drv <= active_green[row];
                end
            end
        end
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Parametrised, brightness-controlled row-scanning driver for bi-colour (red/green) LED matrices; next generation of the fixed 8x8 free-running scanner.
- Adds configurable size, per-row blanking against ghosting, PWM brightness, an enable, and a double-buffered frame load with valid/ready handshake so frames swap only at frame boundaries.
- Sits between the game/graphics logic that produces frames and the board-level row-sink and column-driver pins.

Parameters:
- ROWS, 8, number of matrix rows; must be at least 2.
- COLS, 8, number of matrix columns.
- PWM_BITS, 4, brightness resolution; the drive window per row is 2**PWM_BITS cycles.
- BLANK_CYCLES, 2, all-off cycles at the start of every row; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable.
- brightness  in  PWM_BITS  duty level; 0 = dark.
- red_in  in  ROWS*COLS  pixel (r,c) at bit r*COLS+c; 1 = lit.
- green_in  in  ROWS*COLS  same layout as red_in.
- frame_valid  in  1  producer has a frame on red_in/green_in.
- frame_ready  out  1  pending buffer empty; frame accepted when valid && ready.
- red_drv  out  COLS  red column drivers, active-high.
- green_drv  out  COLS  green column drivers, active-high.
- row_sink  out  ROWS  row sinks, active-low, one-hot-low when driving.
- frame_start  out  1  one-cycle pulse at the start of row 0.

Behaviour:
- Reset (async assert, sync release):
  - row_sink = all 1s; red_drv = green_drv = 0; frame_start = 0; frame_ready = 1.
  - Active and pending buffers cleared; row = 0; state BLANK; phase = 0.
- Buffers:
  - Accept (valid && ready) copies red_in/green_in into the pending buffer and sets pending_full.
  - frame_ready = !pending_full (combinational from the flag).
  - At the cycle that starts row 0 BLANK, if pending_full: pending copies to active and pending_full clears, making frame_ready 1 in the next cycle.
  - An accept in the same cycle as a non-swapping frame boundary (pending empty) loads pending; it displays from the next frame.
- Scan FSM (states BLANK, DRIVE), per row:
  - BLANK: BLANK_CYCLES cycles.
  - DRIVE: 2**PWM_BITS cycles, phase counter p = 0..2**PWM_BITS-1.
  - DRIVE to BLANK of row+1; row wraps from ROWS-1 to 0.
  - Row period = BLANK_CYCLES + 2**PWM_BITS; frame = ROWS x row period.
- Brightness is sampled into a register on the BLANK-to-DRIVE transition and held for the whole row; mid-row changes never glitch.
- Outputs are registered, one cycle after the FSM state that produces them:
  - BLANK: row_sink all 1s, drivers 0.
  - DRIVE: row_sink bit[row] = 0, others 1. If p < sampled brightness, red_drv[c] = active_red(row,c) and green_drv[c] = active_green(row,c); otherwise drivers are 0.
  - Brightness max gives (2**PWM_BITS-1) lit cycles per window.
- frame_start: asserted for one cycle, registered, aligned with the first BLANK output cycle of row 0, including the first frame after reset or enable.
- enable = 0:
  - Next cycle, outputs go to the blank pattern.
  - FSM is held at row 0, BLANK, phase 0; no frame_start.
  - Handshake stays live. If pending_full, it swaps into active immediately and clears.
- enable rising: scan restarts at row 0 BLANK with a frame_start pulse.
- Reset mid-row: outputs go blank immediately (asynchronous); any pending frame is lost.
- Widths: row counter $clog2(ROWS); phase counter max($clog2(BLANK_CYCLES), PWM_BITS); no overflow beyond wrap.

Decomposition:
- Package led_pkg holds:
  - enum scan_state_t {BLANK, DRIVE};
  - default constants for ROWS, COLS, PWM_BITS, BLANK_CYCLES;
  - helper function row_period().
- Sub-module led_frame_buffer: pending/active double buffer, pending_full flag, handshake, and swap/clear inputs.
- Scan FSM and output registers stay in the top module.

Test Plan:
Settings: ROWS=8, COLS=8, PWM_BITS=2, BLANK_CYCLES=2 (row period 6, frame 48).
1. Hold reset_n=0 and toggle clk. Then release with enable=1, brightness=3, buffers empty: row_sink=8'hFF and drivers 0 throughout reset; frame_start pulses on the first post-reset output cycle; then every 48 cycles.
2. Load red row 2 = 8'hF9, handshake at cycle 10 of a frame: frame_ready falls the next cycle. At the next frame_start, ready returns to 1. In row 2, cycles 3-5 of the row show row_sink=8'hFB and red_drv=8'hF9; cycle 6 shows drivers 0 (p=3 is not < 3).
3. brightness=1, green row 7 = 8'hBE: during row 7, exactly 1 cycle has row_sink=8'h7F and green_drv=8'hBE. Change brightness to 3 mid-row: the lit-cycle count stays 1 until the next row.
4. Send two frames back-to-back (A then B) with frame_valid held high: B is stalled (frame_ready=0) until A swaps in; B displays exactly one frame after A; no frame is skipped.
5. Deassert enable mid-row 4: blank outputs the next cycle; a pending frame swaps in while disabled; on re-enable, frame_start pulses and row 0 shows the new frame.
6. brightness=0 for a full frame: drivers stay 0 every cycle while row_sink still scans one-hot-low in DRIVE cycles.
